if_fetch_ctrl: RTL and testbench
================================

Name: if_fetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the instruction memory.
- Owns the program counter and drives the IM read strobe and word address.
- Absorbs the IM's 1-cycle registered read latency with a one-entry skid buffer.
- Presents an instruction/PC pair with a valid flag to decode; honours decode stall, branch redirect and halt.

Parameters:
ADDR_W, 16, IM word-address width (IM is word indexed; PC counts words)
DATA_W, 32, instruction width, equal to the IM data width
RESET_PC, 0, first word address fetched after reset

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
stall  input  1  decode cannot accept this cycle
redirect  input  1  branch/jump taken; load PC from redirect_pc
redirect_pc  input  ADDR_W  redirect target word address
halt  input  1  stop issuing new fetches (level)
im_read  output  1  IM read strobe (combinational from state)
im_addr  output  ADDR_W  IM word address; equals PC register
im_data  input  DATA_W  IM registered read data, valid the cycle after im_read
inst_valid  output  1  inst_out/pc_out hold a valid instruction
inst_out  output  DATA_W  instruction to decode
pc_out  output  ADDR_W  word address of inst_out

Behaviour:
- Clock `clk`, reset `rst`: one clock domain. Reset is synchronous and active-high.
- Registers: state, pc, inflight, inflight_pc, skid_valid, skid_inst, skid_pc.
- Reset values:
  - state=IDLE, pc=RESET_PC, inflight=0, skid_valid=0, skid_inst=0, skid_pc=0.
  - Outputs under reset: im_read=0, im_addr=RESET_PC, inst_valid=0, inst_out=0, pc_out=0.
- States:
  - IDLE: exactly one cycle after reset release (IM is clearing); im_read=0; always goes to RUN.
  - RUN: normal fetch. If halt=1 and redirect=0, go to HALT.
  - HALT: im_read=0; data already in flight or in the skid buffer is still delivered. redirect=1 goes to RUN. halt deasserting with redirect=0 also goes to RUN at the current pc.
- Output mux:
  - skid_valid=1: inst_out=skid_inst, pc_out=skid_pc, inst_valid=1.
  - Else inflight=1: inst_out=im_data, pc_out=inflight_pc, inst_valid=1.
  - Else: inst_valid=0, inst_out=0, pc_out=0.
- Accept: accept = inst_valid & ~stall.
- Issue: im_read = (state==RUN) & ~redirect & ~skid_valid & (~stall | ~inflight).
  - On im_read: pc <= pc+1 (wraps modulo 2^ADDR_W, all-ones goes to 0), inflight <= 1, inflight_pc <= pc.
  - Otherwise inflight <= 0, unless captured as below.
- Skid capture: inflight & stall & ~skid_valid & ~redirect gives skid_valid <= 1, skid_inst <= im_data, skid_pc <= inflight_pc.
- Skid release: skid_valid & ~stall clears skid_valid in the same cycle as the accept.
- Ordering: fetch order is strictly increasing pc between redirects. No instruction is dropped or duplicated under any stall pattern.
- Redirect (highest priority, any state except IDLE):
  - Same cycle: im_read=0 and inst_valid is forced to 0.
  - Next edge: pc <= redirect_pc, inflight <= 0, skid_valid <= 0.
  - Next cycle: issue redirect_pc (if RUN); its instruction is valid on the cycle after that. Redirect-to-first-valid latency is 2 cycles.
- Simultaneous events:
  - redirect+stall: redirect wins.
  - redirect+halt: redirect wins; go to RUN for one cycle, then halt takes effect.
  - stall+halt: no issue; buffered data is held.
- Reset mid-operation: all in-flight and skid state is discarded; the sequence restarts at IDLE and RESET_PC.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - Adds output ports fetch_cnt[31:0] and stall_cnt[31:0], both reset to 0 and wrapping at 2^32.
  - fetch_cnt increments on each accept.
  - stall_cnt increments on each cycle with inst_valid & stall.
- Undefined: both ports and both counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, no stall, IM word k = 0x1000+k -> cycle0 IDLE; cycle1 im_read=1, im_addr=0; cycle2 inst_valid=1, pc_out=0, inst_out=0x1000; then pc_out=1,2,3 back-to-back.
- stall high for 3 cycles starting while addr 5 is in flight -> skid captures 0x1005; inst_out stays 0x1005 and pc_out stays 5 throughout the stall; im_read=0 during the stall; after release, 5 is accepted once and 6 follows with no gap beyond 1 cycle.
- redirect with redirect_pc=0x40 while a skid entry is full and a stall is active -> inst_valid=0 that cycle; next cycle im_addr=0x40; the cycle after, pc_out=0x40; the old skid instruction is never accepted.
- ADDR_W=4, run past pc=0xF -> im_addr sequence 0xE, 0xF, 0x0, 0x1; pc_out follows one cycle later.
- halt asserted at pc=8 -> instructions already in flight are delivered, im_read stays 0, no further accepts; redirect_pc=2 with halt low -> state RUN, pc_out=2 two cycles later.
- FETCH_PERF_CNT_EN: 10 accepts plus 4 stalled-valid cycles -> fetch_cnt=10, stall_cnt=4; rst pulse -> both 0.

Source files
------------

// File: rtl/if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// if_fetch_ctrl
//
// Instruction-fetch sequencer sitting in front of the instruction memory.
// Owns the word-addressed program counter, issues IM reads, absorbs the IM's
// one-cycle registered read latency with a one-entry skid buffer, and hands
// instruction/PC pairs to decode while honouring stall, redirect and halt.
//
// Parameters:
//   ADDR_W    IM word-address width (PC counts words, wraps modulo 2^ADDR_W)
//   DATA_W    instruction / IM data width
//   RESET_PC  first word address fetched after reset
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   stall        decode cannot accept this cycle
//   redirect     branch/jump taken, load PC from redirect_pc
//   redirect_pc  redirect target word address
//   halt         stop issuing new fetches (level)
//   im_read      IM read strobe
//   im_addr      IM word address (the PC register)
//   im_data      IM registered read data, valid the cycle after im_read
//   inst_valid   inst_out/pc_out hold a valid instruction
//   inst_out     instruction to decode
//   pc_out       word address of inst_out
//
// Optional build macro FETCH_PERF_CNT_EN adds:
//   fetch_cnt    count of accepted instructions (wraps at 2^32)
//   stall_cnt    count of cycles with inst_valid & stall (wraps at 2^32)
// ---------------------------------------------------------------------------
module if_fetch_ctrl #(
   parameter int unsigned       ADDR_W   = 16,
   parameter int unsigned       DATA_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              redirect,
   input  logic [ADDR_W-1:0] redirect_pc,
   input  logic              halt,
   output logic              im_read,
   output logic [ADDR_W-1:0] im_addr,
   input  logic [DATA_W-1:0] im_data,
   output logic              inst_valid,
   output logic [DATA_W-1:0] inst_out,
   output logic [ADDR_W-1:0] pc_out
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]       fetch_cnt,
   output logic [31:0]       stall_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   pc;
   logic                inflight;
   logic [ADDR_W-1:0]   inflight_pc;
   logic                skid_valid;
   logic [DATA_W-1:0]   skid_inst;
   logic [ADDR_W-1:0]   skid_pc;
   logic                redir_act;

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Next state and combinational outputs
   // ------------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: state_nx = ST_RUN;
         // redirect together with halt keeps RUN for one more cycle so the
         // redirect target is issued before halt takes effect
         ST_RUN:  if (halt && !redirect) state_nx = ST_HALT;
         ST_HALT: if (redirect || !halt) state_nx = ST_RUN;
         default: state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      // redirect is ignored during the single IDLE cycle after reset
      redir_act = redirect && (state != ST_IDLE);

      // An in-flight word under stall has nowhere to go but the skid buffer,
      // so no new read may be issued while both stall and inflight are set.
      im_read = !rst && (state == ST_RUN) && !redir_act && !skid_valid &&
                (!stall || !inflight);

      im_addr    = pc;
      inst_valid = 1'b0;
      inst_out   = '0;
      pc_out     = '0;
      if (!rst) begin
         if (skid_valid) begin
            inst_valid = 1'b1;
            inst_out   = skid_inst;
            pc_out     = skid_pc;
         end else if (inflight) begin
            inst_valid = 1'b1;
            inst_out   = im_data;
            pc_out     = inflight_pc;
         end
         if (redir_act) begin
            inst_valid = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // PC, in-flight tracking and skid buffer
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
         skid_valid  <= 1'b0;
         skid_inst   <= '0;
         skid_pc     <= '0;
      end else if (redir_act) begin
         pc         <= redirect_pc;
         inflight   <= 1'b0;
         skid_valid <= 1'b0;
      end else begin
         // Every in-flight word is either accepted or captured into the skid
         // this cycle, so inflight simply follows the issue strobe.
         inflight <= im_read;
         if (im_read) begin
            pc          <= pc + ADDR_W'(1);
            inflight_pc <= pc;
         end
         if (skid_valid && !stall) begin
            skid_valid <= 1'b0;
         end else if (inflight && stall && !skid_valid) begin
            skid_valid <= 1'b1;
            skid_inst  <= im_data;
            skid_pc    <= inflight_pc;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   // ------------------------------------------------------------------------
   // Performance counters
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt <= '0;
         stall_cnt <= '0;
      end else begin
         if (inst_valid && !stall) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end
         if (inst_valid && stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
      end
   end
`endif

   // The skid buffer only fills while issue is blocked, and issue stays
   // blocked while it is full, so it never coexists with an in-flight read.
   assert property (@(posedge clk) disable iff (rst) !(skid_valid && inflight));

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_ctrl
//
// Directed bench for if_fetch_ctrl. A table of per-cycle input/expected-output
// rows drives the 16-bit instance through stall, skid, redirect, halt and PC
// wrap scenarios; hand-written sequences cover reset mid-operation, an
// ADDR_W=4 instance wrapping past 0xF, and (with FETCH_PERF_CNT_EN) the
// performance counters. IM word k holds 0x1000 + k.
// ---------------------------------------------------------------------------
module tb_if_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        im_read;
   logic [15:0] im_addr;
   logic [31:0] im_data = '0;
   logic        inst_valid;
   logic [31:0] inst_out;
   logic [15:0] pc_out;

   logic        im_read4;
   logic [3:0]  im_addr4;
   logic [31:0] im_data4 = '0;
   logic        inst_valid4;
   logic [31:0] inst_out4;
   logic [3:0]  pc_out4;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] stall_cnt;
   logic [31:0] fetch_cnt4;
   logic [31:0] stall_cnt4;
`endif

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   // IM models: registered read, one-cycle latency
   always @(posedge clk) begin
      if (im_read)  im_data  <= 32'h1000 + 32'(im_addr);
      if (im_read4) im_data4 <= 32'h1000 + 32'(im_addr4);
   end

   if_fetch_ctrl #(
      .ADDR_W(16),
      .DATA_W(32),
      .RESET_PC(16'h0000)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .im_read     (im_read),
      .im_addr     (im_addr),
      .im_data     (im_data),
      .inst_valid  (inst_valid),
      .inst_out    (inst_out),
      .pc_out      (pc_out)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   if_fetch_ctrl #(
      .ADDR_W(4),
      .DATA_W(32),
      .RESET_PC(4'h0)
   ) u_w4 (
      .clk         (clk),
      .rst         (rst),
      .stall       (1'b0),
      .redirect    (1'b0),
      .redirect_pc (4'h0),
      .halt        (1'b0),
      .im_read     (im_read4),
      .im_addr     (im_addr4),
      .im_data     (im_data4),
      .inst_valid  (inst_valid4),
      .inst_out    (inst_out4),
      .pc_out      (pc_out4)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_cnt   (fetch_cnt4),
      .stall_cnt   (stall_cnt4)
`endif
   );

   typedef struct {
      logic        stall;
      logic        redirect;
      logic [15:0] rpc;
      logic        halt;
      logic        rd;
      logic [15:0] addr;
      logic        v;
      logic [15:0] pc;
   } vec_t;

   vec_t vec[$];

   task automatic add(input logic s, input logic r, input logic [15:0] rpc,
                      input logic h, input logic rd, input logic [15:0] a,
                      input logic v, input logic [15:0] p);
      vec.push_back('{s, r, rpc, h, rd, a, v, p});
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected $finish");
      $fatal(1);
   end

   initial begin
      rst         = 1'b1;
      stall       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      halt        = 1'b0;

      //                s  r  rpc       h   rd addr      v  pc
      add(0, 0, 16'h0,    0,  0, 16'h0,    0, 16'h0);    // c0  IDLE
      add(0, 0, 16'h0,    0,  1, 16'h0,    0, 16'h0);    // c1  first issue
      add(0, 0, 16'h0,    0,  1, 16'h1,    1, 16'h0);
      add(0, 0, 16'h0,    0,  1, 16'h2,    1, 16'h1);
      add(0, 0, 16'h0,    0,  1, 16'h3,    1, 16'h2);
      add(0, 0, 16'h0,    0,  1, 16'h4,    1, 16'h3);
      add(0, 0, 16'h0,    0,  1, 16'h5,    1, 16'h4);    // c6  issue 5
      add(1, 0, 16'h0,    0,  0, 16'h6,    1, 16'h5);    // c7  stall, 5 in flight
      add(1, 0, 16'h0,    0,  0, 16'h6,    1, 16'h5);    // skid holds 5
      add(1, 0, 16'h0,    0,  0, 16'h6,    1, 16'h5);
      add(0, 0, 16'h0,    0,  0, 16'h6,    1, 16'h5);    // c10 accept 5 once
      add(0, 0, 16'h0,    0,  1, 16'h6,    0, 16'h0);    // one-cycle gap
      add(0, 0, 16'h0,    0,  1, 16'h7,    1, 16'h6);
      add(0, 0, 16'h0,    0,  1, 16'h8,    1, 16'h7);
      add(1, 0, 16'h0,    0,  0, 16'h9,    1, 16'h8);    // c14 skid captures 8
      add(1, 1, 16'h40,   0,  0, 16'h9,    0, 16'h0);    // c15 redirect+stall
      add(0, 0, 16'h0,    0,  1, 16'h40,   0, 16'h0);
      add(0, 0, 16'h0,    0,  1, 16'h41,   1, 16'h40);
      add(0, 0, 16'h0,    0,  1, 16'h42,   1, 16'h41);
      add(0, 1, 16'h5,    0,  0, 16'h43,   0, 16'h0);    // c19 redirect to 5
      add(0, 0, 16'h0,    0,  1, 16'h5,    0, 16'h0);
      add(0, 0, 16'h0,    0,  1, 16'h6,    1, 16'h5);
      add(0, 0, 16'h0,    0,  1, 16'h7,    1, 16'h6);
      add(0, 0, 16'h0,    1,  1, 16'h8,    1, 16'h7);    // c23 halt at pc=8
      add(0, 0, 16'h0,    1,  0, 16'h9,    1, 16'h8);    // in-flight delivered
      add(0, 0, 16'h0,    1,  0, 16'h9,    0, 16'h0);
      add(0, 0, 16'h0,    1,  0, 16'h9,    0, 16'h0);
      add(0, 1, 16'h2,    0,  0, 16'h9,    0, 16'h0);    // c27 redirect, halt low
      add(0, 0, 16'h0,    0,  1, 16'h2,    0, 16'h0);
      add(0, 0, 16'h0,    0,  1, 16'h3,    1, 16'h2);
      add(1, 0, 16'h0,    1,  0, 16'h4,    1, 16'h3);    // c30 stall+halt
      add(1, 0, 16'h0,    1,  0, 16'h4,    1, 16'h3);
      add(0, 0, 16'h0,    1,  0, 16'h4,    1, 16'h3);
      add(0, 0, 16'h0,    1,  0, 16'h4,    0, 16'h0);
      add(0, 0, 16'h0,    0,  0, 16'h4,    0, 16'h0);    // halt drops
      add(0, 0, 16'h0,    0,  1, 16'h4,    0, 16'h0);    // resumes at pc 4
      add(0, 0, 16'h0,    0,  1, 16'h5,    1, 16'h4);
      add(0, 1, 16'h10,   1,  0, 16'h6,    0, 16'h0);    // c37 redirect+halt
      add(0, 0, 16'h0,    1,  1, 16'h10,   0, 16'h0);    // one RUN cycle
      add(0, 0, 16'h0,    1,  0, 16'h11,   1, 16'h10);
      add(0, 0, 16'h0,    1,  0, 16'h11,   0, 16'h0);
      add(0, 1, 16'hFFFE, 0,  0, 16'h11,   0, 16'h0);    // c41 go near top
      add(0, 0, 16'h0,    0,  1, 16'hFFFE, 0, 16'h0);
      add(0, 0, 16'h0,    0,  1, 16'hFFFF, 1, 16'hFFFE);
      add(0, 0, 16'h0,    0,  1, 16'h0000, 1, 16'hFFFF); // PC wraps
      add(0, 0, 16'h0,    0,  1, 16'h0001, 1, 16'h0000);

      // Reset state
      next_cycle();
      next_cycle();
      #3;
      chk("reset im_read",    32'(im_read),    32'h0);
      chk("reset im_addr",    32'(im_addr),    32'h0);
      chk("reset inst_valid", 32'(inst_valid), 32'h0);
      chk("reset inst_out",   inst_out,        32'h0);
      chk("reset pc_out",     32'(pc_out),     32'h0);
      next_cycle();
      rst = 1'b0;

      // Table-driven run
      foreach (vec[i]) begin
         stall       = vec[i].stall;
         redirect    = vec[i].redirect;
         redirect_pc = vec[i].rpc;
         halt        = vec[i].halt;
         #3;
         chk($sformatf("row%0d im_read", i),    32'(im_read),    32'(vec[i].rd));
         chk($sformatf("row%0d im_addr", i),    32'(im_addr),    32'(vec[i].addr));
         chk($sformatf("row%0d inst_valid", i), 32'(inst_valid), 32'(vec[i].v));
         if (vec[i].v) begin
            chk($sformatf("row%0d pc_out", i),   32'(pc_out), 32'(vec[i].pc));
            chk($sformatf("row%0d inst_out", i), inst_out,
                32'h1000 + 32'(vec[i].pc));
         end
         next_cycle();
      end

      // Reset mid-operation with a full skid buffer
      stall    = 1'b1;
      redirect = 1'b0;
      halt     = 1'b0;
      next_cycle();                       // skid now holds word 1
      #3;
      chk("pre-reset skid pc_out", 32'(pc_out), 32'h1);
      rst = 1'b1;
      #1;
      chk("in-reset inst_valid", 32'(inst_valid), 32'h0);
      chk("in-reset im_read",    32'(im_read),    32'h0);
      next_cycle();
      #3;
      chk("post-reset im_addr",  32'(im_addr),    32'h0);
      next_cycle();
      rst   = 1'b0;
      stall = 1'b0;
      for (int k = 0; k < 20; k++) begin
         #3;
         if (k == 0) chk("restart c0 im_read", 32'(im_read), 32'h0);
         if (k == 1) chk("restart c1 im_addr", 32'(im_addr), 32'h0);
         if (k == 2) begin
            chk("restart c2 inst_valid", 32'(inst_valid), 32'h1);
            chk("restart c2 pc_out",     32'(pc_out),     32'h0);
            chk("restart c2 inst_out",   inst_out,        32'h1000);
         end
         if (k >= 15 && k <= 18)
            chk($sformatf("w4 c%0d im_addr", k), 32'(im_addr4),
                32'((k - 1) % 16));
         if (k >= 16) begin
            chk($sformatf("w4 c%0d inst_valid", k), 32'(inst_valid4), 32'h1);
            chk($sformatf("w4 c%0d pc_out", k), 32'(pc_out4),
                32'((k - 2) % 16));
            chk($sformatf("w4 c%0d inst_out", k), inst_out4,
                32'h1000 + 32'((k - 2) % 16));
         end
         next_cycle();
      end

`ifdef FETCH_PERF_CNT_EN
      // Counters: 10 accepts and 4 stalled-valid cycles, then reset
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      for (int k = 0; k < 17; k++) begin
         stall = (k >= 7 && k <= 10);
         #3;
         next_cycle();
      end
      stall = 1'b0;
      #3;
      chk("fetch_cnt", fetch_cnt, 32'd10);
      chk("stall_cnt", stall_cnt, 32'd4);
      rst = 1'b1;
      next_cycle();
      #3;
      chk("fetch_cnt after reset", fetch_cnt, 32'd0);
      chk("stall_cnt after reset", stall_cnt, 32'd0);
      rst = 1'b0;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
